sd_backing_source: RTL and testbench
====================================

# sd_backing_source

Synthetic backing store for the fake SD card target. Answers the card core's read-address stream with pattern data in a fixed-latency pipeline. It generalises the single address-slice generator to four pattern modes, parametrised data width and latency, and a writable overlay RAM at the bottom of the address space. It sits between the card emulator's read port and the board top, and adds sequence-checking and read statistics for bench and LED debug.

## Interface
- DATA_W, 8: read data width; 8, 16 or 32. BYTES = DATA_W/8 byte lanes.
- ADDR_W, 64: byte address width.
- LATENCY, 1: cycles from accepted request to `rdvalid`; legal range 1..4.
- OVL_DEPTH, 1024: overlay RAM size in bytes; power of two.
- `rdclk` in 1: the single clock; all logic runs on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mode` in 2: pattern select; sampled with each request.
- `seed` in 32: LFSR seed.
- `const_byte` in 8: fill value for CONST mode.
- `ovl_en` in 1: enables overlay reads.
- `rdreq` in 1: read request strobe.
- `rdaddr` in ADDR_W: byte address of lane 0. The low log2(BYTES) bits are ignored and treated as 0.
- `rddata` out DATA_W: lane i holds the byte at address addr+i (little-endian).
- `rdvalid` out 1: `rddata` is valid this cycle.
- `wr_en` in 1: overlay byte write strobe.
- `wr_addr` in log2(OVL_DEPTH): overlay write address.
- `wr_data` in 8: overlay write data.
- `seq_err` out 1: sticky flag; set when an LFSR-mode read jumps non-sequentially mid-sector.
- `rd_count` out 32: number of accepted requests; saturates at 0xFFFF_FFFF.

## Operation
- Sector index `sec` = addr[ADDR_W-1:9]. Byte offset within sector `off` = addr[8:0].
- Pattern modes (per byte at address a):
  - Mode 0 ADDR: {a[11:8], a[3:0]}.
  - Mode 1 LFSR: see below.
  - Mode 2 CONST: `const_byte`.
  - Mode 3 INC: a[7:0] + sec[7:0], mod 256.
- LFSR state is 32 bits. Each byte outputs state[7:0], then the state takes one right-shift Galois step:
  - lsb = state[0]; state >>= 1; if lsb, state ^= 0x80200003.
  - A beat consumes BYTES steps in lane order.
- LFSR reload: state = seed ^ sec[31:0]; if the result is 0, use 0xFFFF_FFFF instead. Reload happens when any of the following holds:
  - off == 0;
  - the previous request was not LFSR mode;
  - addr != previous addr + BYTES.
- A reload caused by a non-sequential address with off != 0 sets `seq_err`. The data then comes from the reloaded state, with the offset ignored.
- Overlay: when `ovl_en`=1 and a < OVL_DEPTH, the overlay RAM byte replaces the pattern byte. The decision is made per lane.
- Write collisions: a write in the same cycle as a read of the same byte returns the old RAM value (read-before-write).
- `seq_err` clears only on reset.
- `rd_count` increments on every `rdreq` cycle.

## Timing
- Fixed pipeline: a request in cycle N produces `rdvalid`=1 with its data in cycle N+LATENCY.
- Back-to-back requests every cycle are supported; there is no backpressure.
- `rddata` holds its last value when `rdvalid`=0.
- The LFSR state and the "previous address" register update in the request cycle.
- Reset values: `rddata`=0, `rdvalid`=0, `seq_err`=0, `rd_count`=0, LFSR state=0xFFFF_FFFF.
- Reset asserted mid-stream: in-flight beats are discarded, and `rdvalid` is 0 immediately (asynchronous). The first request after reset always reloads the LFSR.
- Overlay RAM contents are not reset and are retained across `rst_n`.
- A `mode` change between requests takes effect on the next request. Beats already in flight are not affected.

## Structure
- Package `sd_backing_pkg` holds:
  - enum `sd_pat_mode_t` {PAT_ADDR, PAT_LFSR, PAT_CONST, PAT_INC};
  - constant `LFSR_TAPS` = 32'h80200003;
  - function `lfsr_step`;
  - constant `SECTOR_SHIFT` = 9.
- Sub-module `sd_backing_overlay_ram`: BYTES read ports plus one write port, synchronous read, read-before-write behaviour.
- Pattern lanes are generated by a loop over BYTES.
- The delay line is a LATENCY-deep shift register of {valid, data}.

## Test plan
- Mode 0, DATA_W=8, LATENCY=1: read 0x0ABC → one cycle later `rdvalid`=1, `rddata`=0xAC. Read 0x10 → 0x00.
- Mode 1, seed=1: read 0x000 then 0x001 → 0x01 then 0x03. Then read 0x205 → 0xFF (sector 1 reloads to 0xFFFF_FFFF), and `seq_err`=1 stays set.
- Overlay: write 0x5A at 0x10. With `ovl_en`=1, read 0x10 → 0x5A; with `ovl_en`=0, read 0x10 → 0x00. Same-cycle write of 0x77 while reading 0x10 → read returns 0x5A, next read returns 0x77.
- DATA_W=32, LATENCY=3, mode 3: read 0x204 → after 3 cycles `rddata`=0x08070605.
- Streaming: 600 consecutive requests every cycle → 600 `rdvalid` pulses, each aligned to its request; `rd_count`=600.
- Reset mid-stream with 2 beats in flight → `rdvalid` drops at once and no stale beat emerges. `seq_err`=0, `rd_count`=0, overlay data retained.

Source files
------------

// File: rtl/sd_backing_pkg.sv
// Shared types and helpers for the synthetic SD backing store.
package sd_backing_pkg;

  typedef enum logic [1:0] {
    PAT_ADDR  = 2'd0,
    PAT_LFSR  = 2'd1,
    PAT_CONST = 2'd2,
    PAT_INC   = 2'd3
  } sd_pat_mode_t;

  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [31:0] LFSR_INIT    = 32'hFFFF_FFFF;
  localparam int          SECTOR_SHIFT = 9;

  // One right-shift Galois step of the 32-bit pattern LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] state);
    logic [31:0] nxt;
    nxt = state >> 1;
    if (state[0]) nxt = nxt ^ LFSR_TAPS;
    return nxt;
  endfunction

  // Sector-start state; an all-zero state would lock up, so it is replaced.
  function automatic logic [31:0] lfsr_reload(input logic [31:0] seed, input logic [31:0] sec);
    logic [31:0] s;
    s = seed ^ sec;
    return (s == '0) ? LFSR_INIT : s;
  endfunction

endpackage

// File: rtl/sd_backing_overlay_ram.sv
// Byte-wide overlay RAM: one read port per lane, one write port,
// synchronous read, read-before-write on address collision.
module sd_backing_overlay_ram #(
  parameter int DEPTH = 1024,
  parameter int PORTS = 1
) (
  input  logic                               clk,
  input  logic                               rd_en,
  input  logic [PORTS-1:0][$clog2(DEPTH)-1:0] rd_addr,
  output logic [PORTS-1:0][7:0]              rd_data,
  input  logic                               wr_en,
  input  logic [$clog2(DEPTH)-1:0]           wr_addr,
  input  logic [7:0]                         wr_data
);

  logic [7:0]            mem_q [DEPTH];
  logic [PORTS-1:0][7:0] rd_data_q;

  // Write and read share one edge; the read samples the pre-write contents.
  // NOTE: the array has no reset: contents must survive rst_n, and a reset
  // would stop the array mapping onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) begin
      for (int p = 0; p < PORTS; p++) rd_data_q[p] <= mem_q[rd_addr[p]];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sd_backing_source.sv
// Fixed-latency pattern source answering the card core's read stream,
// with LFSR sequence checking, a low-address overlay RAM and read stats.
module sd_backing_source
  import sd_backing_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 64,
  parameter int LATENCY   = 1,
  parameter int OVL_DEPTH = 1024
) (
  input  logic                         rdclk,
  input  logic                         rst_n,
  input  logic [1:0]                   mode,
  input  logic [31:0]                  seed,
  input  logic [7:0]                   const_byte,
  input  logic                         ovl_en,
  input  logic                         rdreq,
  input  logic [ADDR_W-1:0]            rdaddr,
  output logic [DATA_W-1:0]            rddata,
  output logic                         rdvalid,
  input  logic                         wr_en,
  input  logic [$clog2(OVL_DEPTH)-1:0] wr_addr,
  input  logic [7:0]                   wr_data,
  output logic                         seq_err,
  output logic [31:0]                  rd_count
);

  localparam int BYTES  = DATA_W / 8;
  localparam int OVL_AW = $clog2(OVL_DEPTH);

  sd_pat_mode_t              mode_e;
  logic [ADDR_W-1:0]         addr_al;
  logic [31:0]               sec32;
  logic [SECTOR_SHIFT-1:0]   off;
  logic                      seq_hit, reload, jump;
  logic [BYTES-1:0][7:0]     pat;
  logic [BYTES-1:0]          ovl_sel;
  logic [BYTES-1:0][OVL_AW-1:0] ram_addr;
  logic [BYTES-1:0][7:0]     ram_rd;
  logic [31:0]               lfsr_next;
  logic [DATA_W-1:0]         beat0;

  logic [31:0]           lfsr_q, lfsr_d;
  logic [ADDR_W-1:0]     prev_addr_q, prev_addr_d;
  logic                  prev_lfsr_q, prev_lfsr_d;
  logic                  prev_vld_q, prev_vld_d;
  logic                  seq_err_q, seq_err_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [BYTES-1:0][7:0] pat_q, pat_d;
  logic [BYTES-1:0]      sel_q, sel_d;
  logic [LATENCY-1:0]    vld_q, vld_d;

  assign mode_e = sd_pat_mode_t'(mode);

  // Decode the request address and decide whether the LFSR must reload.
  always_comb begin
    addr_al = rdaddr & ~ADDR_W'(BYTES - 1);
    sec32   = 32'(addr_al >> SECTOR_SHIFT);
    off     = addr_al[SECTOR_SHIFT-1:0];
    seq_hit = prev_vld_q && (addr_al == prev_addr_q + ADDR_W'(BYTES));
    reload  = (off == '0) || !prev_lfsr_q || !seq_hit;
    jump    = prev_vld_q && prev_lfsr_q && !seq_hit && (off != '0);
  end

  // Generate the pattern byte and overlay decision for every lane.
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [31:0]       st;
    // NOTE: blocking '=' is right here: 'st' is a running temporary stepped
    // lane by lane inside a single evaluation, not a register.
    st       = reload ? lfsr_reload(seed, sec32) : lfsr_q;
    a        = '0;
    pat      = '0;
    ovl_sel  = '0;
    ram_addr = '0;
    for (int i = 0; i < BYTES; i++) begin
      a           = addr_al + ADDR_W'(i);
      ovl_sel[i]  = ovl_en && (a < ADDR_W'(OVL_DEPTH));
      ram_addr[i] = a[OVL_AW-1:0];
      case (mode_e)
        PAT_ADDR:  pat[i] = {a[11:8], a[3:0]};
        PAT_LFSR: begin
          pat[i] = st[7:0];
          st     = lfsr_step(st);
        end
        PAT_CONST: pat[i] = const_byte;
        default:   pat[i] = a[7:0] + sec32[7:0];
      endcase
    end
    lfsr_next = st;
  end

  // Request-cycle state updates: LFSR, previous address, flags, statistics.
  always_comb begin
    // NOTE: every output gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    lfsr_d      = lfsr_q;
    prev_addr_d = prev_addr_q;
    prev_lfsr_d = prev_lfsr_q;
    prev_vld_d  = prev_vld_q;
    seq_err_d   = seq_err_q;
    cnt_d       = cnt_q;
    pat_d       = pat_q;
    sel_d       = sel_q;
    if (rdreq) begin
      prev_addr_d = addr_al;
      prev_lfsr_d = (mode_e == PAT_LFSR);
      prev_vld_d  = 1'b1;
      pat_d       = pat;
      sel_d       = ovl_sel;
      if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
      if (mode_e == PAT_LFSR) begin
        lfsr_d = lfsr_next;
        if (jump) seq_err_d = 1'b1;
      end
    end
  end

  // Valid bits advance every cycle; stage 0 is the request just accepted.
  always_comb begin
    vld_d[0] = rdreq;
    for (int k = 1; k < LATENCY; k++) vld_d[k] = vld_q[k-1];
  end

  // Stage-0 beat: overlay byte replaces the pattern byte lane by lane.
  always_comb begin
    beat0 = '0;
    for (int i = 0; i < BYTES; i++) beat0[i*8 +: 8] = sel_q[i] ? ram_rd[i] : pat_q[i];
  end

  // State registers.
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q      <= LFSR_INIT;
      prev_addr_q <= '0;
      prev_lfsr_q <= 1'b0;
      prev_vld_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      cnt_q       <= '0;
      pat_q       <= '0;
      sel_q       <= '0;
      vld_q       <= '0;
    end else begin
      lfsr_q      <= lfsr_d;
      prev_addr_q <= prev_addr_d;
      prev_lfsr_q <= prev_lfsr_d;
      prev_vld_q  <= prev_vld_d;
      seq_err_q   <= seq_err_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      sel_q       <= sel_d;
      vld_q       <= vld_d;
    end
  end

  sd_backing_overlay_ram #(
    .DEPTH (OVL_DEPTH),
    .PORTS (BYTES)
  ) u_ovl (
    .clk     (rdclk),
    .rd_en   (rdreq),
    .rd_addr (ram_addr),
    .rd_data (ram_rd),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  if (LATENCY == 1) begin : g_no_line
    assign rddata = beat0;
  end else begin : g_line
    logic [DATA_W-1:0] dat_q [LATENCY-1];
    logic [DATA_W-1:0] dat_d [LATENCY-1];

    // Data stages load only behind a valid beat so rddata holds when idle.
    always_comb begin
      dat_d[0] = vld_q[0] ? beat0 : dat_q[0];
      for (int j = 1; j < LATENCY - 1; j++) dat_d[j] = vld_q[j] ? dat_q[j-1] : dat_q[j];
    end

    // Data delay-line registers.
    always_ff @(posedge rdclk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < LATENCY - 1; j++) dat_q[j] <= '0;
      end else begin
        dat_q <= dat_d;
      end
    end

    assign rddata = dat_q[LATENCY-2];
  end

  assign rdvalid  = vld_q[LATENCY-1];
  assign seq_err  = seq_err_q;
  assign rd_count = cnt_q;

endmodule

// File: tb/tb_sd_backing_source.sv
// Directed bench: narrow instance (8-bit, latency 1) and wide instance
// (32-bit, latency 3) sharing clock and reset.
module tb_sd_backing_source;
  import sd_backing_pkg::*;

  logic rdclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 rdclk = ~rdclk;

  logic [1:0]  n_mode, w_mode;
  logic [31:0] n_seed, w_seed;
  logic [7:0]  n_const, w_const;
  logic        n_ovl_en, w_ovl_en, n_rdreq, w_rdreq;
  logic [63:0] n_rdaddr, w_rdaddr;
  logic [7:0]  n_rddata;
  logic [31:0] w_rddata;
  logic        n_rdvalid, w_rdvalid, n_wr_en, w_wr_en;
  logic [9:0]  n_wr_addr, w_wr_addr;
  logic [7:0]  n_wr_data, w_wr_data;
  logic        n_seq_err, w_seq_err;
  logic [31:0] n_rd_count, w_rd_count;

  int n_checks = 0;
  int n_bad    = 0;

  sd_backing_source #(.DATA_W(8), .ADDR_W(64), .LATENCY(1), .OVL_DEPTH(1024)) u_narrow (
    .rdclk(rdclk), .rst_n(rst_n), .mode(n_mode), .seed(n_seed), .const_byte(n_const),
    .ovl_en(n_ovl_en), .rdreq(n_rdreq), .rdaddr(n_rdaddr), .rddata(n_rddata),
    .rdvalid(n_rdvalid), .wr_en(n_wr_en), .wr_addr(n_wr_addr), .wr_data(n_wr_data),
    .seq_err(n_seq_err), .rd_count(n_rd_count));

  sd_backing_source #(.DATA_W(32), .ADDR_W(64), .LATENCY(3), .OVL_DEPTH(1024)) u_wide (
    .rdclk(rdclk), .rst_n(rst_n), .mode(w_mode), .seed(w_seed), .const_byte(w_const),
    .ovl_en(w_ovl_en), .rdreq(w_rdreq), .rdaddr(w_rdaddr), .rddata(w_rddata),
    .rdvalid(w_rdvalid), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .seq_err(w_seq_err), .rd_count(w_rd_count));

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge rdclk); #1;
    rst_n = 1'b1;
  endtask

  // One narrow request; samples the output just after the accepting edge.
  task automatic n_read(input logic [63:0] addr, output logic valid, output logic [7:0] data);
    n_rdaddr = addr;
    n_rdreq  = 1'b1;
    @(posedge rdclk); #1;
    n_rdreq  = 1'b0;
    valid    = n_rdvalid;
    data     = n_rddata;
  endtask

  // One wide request; waits (bounded) for rdvalid and reports latency in edges.
  task automatic w_read(input logic [63:0] addr, output int lat, output logic [31:0] data);
    w_rdaddr = addr;
    w_rdreq  = 1'b1;
    @(posedge rdclk); #1;
    w_rdreq  = 1'b0;
    lat      = -1;
    data     = '0;
    for (int c = 1; c <= 8; c++) begin
      if (w_rdvalid) begin
        lat  = c;
        data = w_rddata;
        break;
      end
      @(posedge rdclk); #1;
    end
  endtask

  task automatic test_reset();
    n_mode = PAT_ADDR; n_seed = '0; n_const = '0; n_ovl_en = 1'b0; n_rdreq = 1'b0;
    n_rdaddr = '0; n_wr_en = 1'b0; n_wr_addr = '0; n_wr_data = '0;
    w_mode = PAT_ADDR; w_seed = '0; w_const = '0; w_ovl_en = 1'b0; w_rdreq = 1'b0;
    w_rdaddr = '0; w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
    rst_n = 1'b0;
    #3;
    n_checks++;
    if (n_rdvalid !== 1'b0 || n_rddata !== 8'h00 || n_seq_err !== 1'b0 || n_rd_count !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_narrow got vld=%b data=%h seq=%b cnt=%0d want 0/00/0/0",
               n_rdvalid, n_rddata, n_seq_err, n_rd_count);
    end
    n_checks++;
    if (w_rdvalid !== 1'b0 || w_rddata !== 32'h0 || w_seq_err !== 1'b0 || w_rd_count !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_wide got vld=%b data=%h seq=%b cnt=%0d want 0/0/0/0",
               w_rdvalid, w_rddata, w_seq_err, w_rd_count);
    end
    @(posedge rdclk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_addr_mode();
    logic [63:0] addrs [3] = '{64'h0ABC, 64'h0010, 64'h0FFF};
    logic [7:0]  exps  [3] = '{8'hAC, 8'h00, 8'hFF};
    logic v; logic [7:0] d;
    n_mode = PAT_ADDR; n_ovl_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_read(addrs[i], v, d);
      n_checks++;
      if (v !== 1'b1 || d !== exps[i]) begin
        n_bad++;
        $display("FAIL addr_mode[%0d] addr=%h got vld=%b data=%h want 1/%h", i, addrs[i], v, d, exps[i]);
      end
    end
    @(posedge rdclk); #1;
    n_checks++;
    if (n_rdvalid !== 1'b0 || n_rddata !== 8'hFF) begin
      n_bad++;
      $display("FAIL idle_hold got vld=%b data=%h want 0/ff", n_rdvalid, n_rddata);
    end
    n_checks++;
    if (n_rd_count !== 32'd3) begin
      n_bad++;
      $display("FAIL rd_count_after_3 got %0d want 3", n_rd_count);
    end
  endtask

  task automatic test_lfsr();
    logic [63:0] addrs [5] = '{64'h000, 64'h001, 64'h205, 64'h206, 64'h400};
    logic [7:0]  exps  [5] = '{8'h01, 8'h03, 8'hFF, 8'hFC, 8'h03};
    logic        errs  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic v; logic [7:0] d;
    n_mode = PAT_LFSR; n_seed = 32'd1; n_ovl_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_read(addrs[i], v, d);
      n_checks++;
      if (v !== 1'b1 || d !== exps[i] || n_seq_err !== errs[i]) begin
        n_bad++;
        $display("FAIL lfsr[%0d] addr=%h got vld=%b data=%h seq=%b want 1/%h/%b",
                 i, addrs[i], v, d, n_seq_err, exps[i], errs[i]);
      end
    end
    n_mode = PAT_ADDR;
    n_read(64'h0ABC, v, d);
    n_checks++;
    if (n_seq_err !== 1'b1 || d !== 8'hAC) begin
      n_bad++;
      $display("FAIL seq_err_sticky got seq=%b data=%h want 1/ac", n_seq_err, d);
    end
  endtask

  task automatic test_const_inc();
    logic [1:0]  modes [4] = '{PAT_CONST, PAT_INC, PAT_INC, PAT_INC};
    logic [63:0] addrs [4] = '{64'h123, 64'h2FF, 64'h010, 64'h3FC};
    logic [7:0]  exps  [4] = '{8'hC3, 8'h00, 8'h10, 8'hFD};
    logic v; logic [7:0] d;
    n_const = 8'hC3; n_ovl_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_mode = modes[i];
      n_read(addrs[i], v, d);
      n_checks++;
      if (v !== 1'b1 || d !== exps[i]) begin
        n_bad++;
        $display("FAIL const_inc[%0d] addr=%h got vld=%b data=%h want 1/%h", i, addrs[i], v, d, exps[i]);
      end
    end
  endtask

  task automatic test_overlay();
    logic v; logic [7:0] d;
    n_mode = PAT_ADDR;
    n_wr_en = 1'b1; n_wr_addr = 10'h010; n_wr_data = 8'h5A;
    @(posedge rdclk); #1;
    n_wr_en = 1'b0;
    n_ovl_en = 1'b1;
    n_read(64'h10, v, d);
    n_checks++;
    if (v !== 1'b1 || d !== 8'h5A) begin
      n_bad++; $display("FAIL ovl_on got vld=%b data=%h want 1/5a", v, d);
    end
    n_ovl_en = 1'b0;
    n_read(64'h10, v, d);
    n_checks++;
    if (v !== 1'b1 || d !== 8'h00) begin
      n_bad++; $display("FAIL ovl_off got vld=%b data=%h want 1/00", v, d);
    end
    n_ovl_en = 1'b1;
    n_wr_en = 1'b1; n_wr_addr = 10'h010; n_wr_data = 8'h77;
    n_read(64'h10, v, d);
    n_wr_en = 1'b0;
    n_checks++;
    if (v !== 1'b1 || d !== 8'h5A) begin
      n_bad++; $display("FAIL ovl_collision got data=%h want 5a (old value)", d);
    end
    n_read(64'h10, v, d);
    n_checks++;
    if (v !== 1'b1 || d !== 8'h77) begin
      n_bad++; $display("FAIL ovl_after_write got data=%h want 77", d);
    end
    n_read(64'h410, v, d);
    n_checks++;
    if (v !== 1'b1 || d !== 8'h40) begin
      n_bad++; $display("FAIL ovl_above_depth got data=%h want 40", d);
    end
  endtask

  task automatic test_wide();
    logic [1:0]  modes [4] = '{PAT_INC, PAT_INC, PAT_LFSR, PAT_CONST};
    logic [63:0] addrs [4] = '{64'h204, 64'h207, 64'h000, 64'h1000};
    logic [31:0] exps  [4] = '{32'h08070605, 32'h08070605, 32'h01020301, 32'h5C5C5C5C};
    int lat; logic [31:0] d;
    w_seed = 32'd1; w_const = 8'h5C; w_ovl_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_mode = modes[i];
      w_read(addrs[i], lat, d);
      n_checks++;
      if (lat != 3 || d !== exps[i]) begin
        n_bad++;
        $display("FAIL wide[%0d] addr=%h got lat=%0d data=%h want 3/%h", i, addrs[i], lat, d, exps[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exps [3] = '{32'h08070605, 32'h47464544, 32'h47464544};
    logic        vlds [3] = '{1'b1, 1'b1, 1'b0};
    @(posedge rdclk); #1;
    w_mode = PAT_INC;  w_rdaddr = 64'h204; w_rdreq = 1'b1;
    @(posedge rdclk); #1;
    w_mode = PAT_ADDR; w_rdaddr = 64'h404;
    @(posedge rdclk); #1;
    w_rdreq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge rdclk); #1;
      n_checks++;
      if (w_rdvalid !== vlds[i] || w_rddata !== exps[i]) begin
        n_bad++;
        $display("FAIL b2b[%0d] got vld=%b data=%h want %b/%h", i, w_rdvalid, w_rddata, vlds[i], exps[i]);
      end
    end
  endtask

  task automatic test_streaming();
    int pulses = 0;
    int errs   = 0;
    logic [63:0] a;
    logic [7:0]  exp;
    do_reset();
    n_mode = PAT_ADDR; n_ovl_en = 1'b0;
    for (int i = 0; i < 604; i++) begin
      a        = 64'h400 + 64'(i);
      n_rdreq  = (i < 600);
      n_rdaddr = a;
      exp      = {a[11:8], a[3:0]};
      @(posedge rdclk); #1;
      if (n_rdvalid) pulses++;
      if (i < 600) begin
        if (n_rdvalid !== 1'b1 || n_rddata !== exp) errs++;
      end else if (n_rdvalid !== 1'b0) begin
        errs++;
      end
    end
    n_rdreq = 1'b0;
    n_checks++;
    if (pulses != 600) begin
      n_bad++; $display("FAIL stream_pulses got %0d want 600", pulses);
    end
    n_checks++;
    if (errs != 0) begin
      n_bad++; $display("FAIL stream_alignment got %0d bad beats want 0", errs);
    end
    n_checks++;
    if (n_rd_count !== 32'd600) begin
      n_bad++; $display("FAIL stream_rd_count got %0d want 600", n_rd_count);
    end
  endtask

  task automatic test_reset_midstream();
    logic v; logic [7:0] d;
    int stale = 0;
    n_mode = PAT_LFSR; n_seed = 32'd1; n_ovl_en = 1'b0;
    n_read(64'h000, v, d);
    n_read(64'h005, v, d);
    n_checks++;
    if (n_seq_err !== 1'b1 || d !== 8'h01) begin
      n_bad++; $display("FAIL jump_sets_seq_err got seq=%b data=%h want 1/01", n_seq_err, d);
    end
    w_mode = PAT_INC; w_ovl_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w_rdaddr = 64'h204 + 64'(4 * k);
      w_rdreq  = 1'b1;
      @(posedge rdclk); #1;
    end
    w_rdreq = 1'b0;
    n_checks++;
    if (w_rdvalid !== 1'b1 || w_rddata !== 32'h08070605) begin
      n_bad++; $display("FAIL midstream_first_beat got vld=%b data=%h want 1/08070605", w_rdvalid, w_rddata);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (w_rdvalid !== 1'b0 || w_rd_count !== 32'd0 || n_seq_err !== 1'b0 || n_rd_count !== 32'd0) begin
      n_bad++;
      $display("FAIL async_reset got wvld=%b wcnt=%0d nseq=%b ncnt=%0d want 0/0/0/0",
               w_rdvalid, w_rd_count, n_seq_err, n_rd_count);
    end
    @(posedge rdclk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge rdclk); #1;
      if (w_rdvalid !== 1'b0 || n_rdvalid !== 1'b0) stale++;
    end
    n_checks++;
    if (stale != 0 || w_rddata !== 32'h0) begin
      n_bad++; $display("FAIL stale_beats got %0d stale, data=%h want 0/0", stale, w_rddata);
    end
    n_mode = PAT_LFSR;
    n_read(64'h001, v, d);
    n_checks++;
    if (v !== 1'b1 || d !== 8'h01) begin
      n_bad++; $display("FAIL reload_after_reset got vld=%b data=%h want 1/01", v, d);
    end
    n_mode = PAT_ADDR; n_ovl_en = 1'b1;
    n_read(64'h10, v, d);
    n_checks++;
    if (v !== 1'b1 || d !== 8'h77) begin
      n_bad++; $display("FAIL ovl_retained got vld=%b data=%h want 1/77", v, d);
    end
  endtask

  initial begin
    test_reset();
    test_addr_mode();
    test_lfsr();
    test_const_inc();
    test_overlay();
    test_wide();
    test_back_to_back();
    test_streaming();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout after 1 ms");
    $fatal(1, "watchdog");
  end

endmodule
